// File: rtl/act_arb_pkg.sv
// act_arb_pkg: shared sizes and result types for the activation-unit arbiter
//   NUM_REQ  number of requesters sharing the activation unit
//   DATA_W   signed pixel width
//   ID_W     requester id width
package act_arb_pkg;
  localparam int NUM_REQ = 4;
  localparam int DATA_W = 22;
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  typedef logic signed [DATA_W-1:0] pixel_t;
  typedef logic [ID_W-1:0] req_id_t;
  typedef struct packed {
    pixel_t data;
    req_id_t id;
  } result_entry_t;
endpackage

// File: rtl/act_arb_result_fifo.sv
// act_arb_result_fifo: synchronous FIFO of tagged activation results
//   clk, rst      clock, synchronous active-low reset
//   push, wr_data write one entry (caller guarantees not full unless popping)
//   pop, rd_data  head entry, consumed on pop (caller guarantees not empty)
//   count         occupancy; full/empty flags
module act_arb_result_fifo
  import act_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  result_entry_t          wr_data,
  input  logic                   pop,
  output result_entry_t          rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  result_entry_t mem_q [DEPTH];
  always_comb begin
    wr_d = push ? wr_q + AW'(1) : wr_q;
    rd_d = pop ? rd_q + AW'(1) : rd_q;
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      if (push) mem_q[wr_q] <= wr_data;
    end
  end
  assign rd_data = mem_q[rd_q];
  assign count = cnt_q;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
endmodule

// File: rtl/act_unit_arbiter.sv
// act_unit_arbiter: round-robin sharing of one ReLU unit with tagged, credit-bounded result return
//   clk, rst                       clock, synchronous active-low reset
//   req_valid/req_data/req_ready   per-requester pixel handshake
//   act_pixel_valid/act_pixel_in   issue to the activation unit
//   act_result_valid/act_result_out results from the activation unit
//   out_valid/out_data/out_id/out_ready  tagged result stream
//   err_sync                       sticky: untagged result or overflowing push
//   grant_count                    per-requester saturating handshake counters (ACT_ARB_STATS_EN only)
module act_unit_arbiter
  import act_arb_pkg::*;
#(
  parameter int ACT_LAT = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic                             act_pixel_valid,
  output logic [DATA_W-1:0]                act_pixel_in,
  input  logic                             act_result_valid,
  input  logic [DATA_W-1:0]                act_result_out,
  output logic                             out_valid,
  output logic [DATA_W-1:0]                out_data,
  output logic [ID_W-1:0]                  out_id,
  input  logic                             out_ready,
`ifdef ACT_ARB_STATS_EN
  output logic [NUM_REQ-1:0][15:0]         grant_count,
`endif
  output logic                             err_sync
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  req_id_t rr_q, rr_d, win, idx;
  logic found, issue_ok, hs, push_req, push, pop, full, empty;
  logic err_q, err_d, act_v_q, act_v_d;
  logic [DATA_W-1:0] act_d_q, act_d_d;
  logic [CW-1:0] fifo_count, in_flight_q, in_flight_d;
  logic [ACT_LAT:0] tag_v_q, tag_v_d;
  logic [ACT_LAT:0][ID_W-1:0] tag_id_q, tag_id_d;
  result_entry_t wr_e, head;
  // scanning downward leaves the lowest offset from the pointer as the winner
  always_comb begin
    win = '0;
    idx = '0;
    found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = req_id_t'((int'(rr_q) + i) % NUM_REQ);
      if (req_valid[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
  end
  // credit covers pixels inside the non-stallable unit plus buffered results
  always_comb begin
    issue_ok = (CW+1)'(in_flight_q) + (CW+1)'(fifo_count) < (CW+1)'(FIFO_DEPTH);
    hs = found & issue_ok;
    req_ready = hs ? NUM_REQ'(1) << win : '0;
    rr_d = !hs ? rr_q : (int'(win) == NUM_REQ - 1) ? '0 : win + ID_W'(1);
    act_v_d = hs;
    act_d_d = hs ? req_data[win] : act_d_q;
    tag_v_d[0] = hs;
    tag_id_d[0] = win;
    for (int i = 1; i <= ACT_LAT; i++) begin
      tag_v_d[i] = tag_v_q[i-1];
      tag_id_d[i] = tag_id_q[i-1];
    end
    pop = ~empty & out_ready;
    push_req = act_result_valid & tag_v_q[ACT_LAT];
    push = push_req & (~full | pop);
    wr_e.data = act_result_out;
    wr_e.id = tag_id_q[ACT_LAT];
    in_flight_d = in_flight_q + CW'(hs) - CW'(push_req);
    err_d = err_q | (act_result_valid & ~tag_v_q[ACT_LAT]) | (push_req & ~push);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_q <= '0;
      act_v_q <= 1'b0;
      act_d_q <= '0;
      tag_v_q <= '0;
      tag_id_q <= '0;
      in_flight_q <= '0;
      err_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
      act_v_q <= act_v_d;
      act_d_q <= act_d_d;
      tag_v_q <= tag_v_d;
      tag_id_q <= tag_id_d;
      in_flight_q <= in_flight_d;
      err_q <= err_d;
    end
  end
  act_arb_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .wr_data(wr_e), .pop(pop),
    .rd_data(head), .count(fifo_count), .full(full), .empty(empty)
  );
  assign act_pixel_valid = act_v_q;
  assign act_pixel_in = act_d_q;
  assign out_valid = ~empty;
  assign out_data = head.data;
  assign out_id = head.id;
  assign err_sync = err_q;
`ifdef ACT_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] grant_q, grant_d;
  always_comb begin
    grant_d = grant_q;
    for (int i = 0; i < NUM_REQ; i++)
      if (hs && int'(win) == i && grant_q[i] != 16'hFFFF) grant_d[i] = grant_q[i] + 16'd1;
  end
  always_ff @(posedge clk) grant_q <= !rst ? '0 : grant_d;
  assign grant_count = grant_q;
`endif
endmodule

// File: tb/tb_act_unit_arbiter.sv
// tb_act_unit_arbiter: directed scoreboard bench with a reset-able ReLU model as the activation unit
module tb_act_unit_arbiter;
  import act_arb_pkg::*;
  logic clk = 1'b0;
  logic rst;
  logic [NUM_REQ-1:0] req_valid, req_ready;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
  logic act_pixel_valid, act_result_valid, out_valid, out_ready, err_sync, spur;
  logic [DATA_W-1:0] act_pixel_in, act_result_out, out_data;
  logic [ID_W-1:0] out_id;
  logic m_v = 1'b0;
  logic [DATA_W-1:0] m_d = '0;
`ifdef ACT_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] grant_count;
`endif
  int checks = 0, failures = 0, cyc = 0, hs_cnt = 0, h0;
  bit chk_lat = 1'b1;
  typedef struct {
    logic [DATA_W-1:0] d;
    int id;
    int c;
  } sb_t;
  sb_t exp_q[$];
  logic [NUM_REQ-1:0] t4 [3] = '{4'b1000, 4'b0010, 4'b1000};

  always #5 clk = ~clk;

  act_unit_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .act_pixel_valid(act_pixel_valid), .act_pixel_in(act_pixel_in),
    .act_result_valid(act_result_valid), .act_result_out(act_result_out),
    .out_valid(out_valid), .out_data(out_data), .out_id(out_id), .out_ready(out_ready),
`ifdef ACT_ARB_STATS_EN
    .grant_count(grant_count),
`endif
    .err_sync(err_sync)
  );

  function automatic logic [DATA_W-1:0] relu(input logic [DATA_W-1:0] x);
    return x[DATA_W-1] ? '0 : x;
  endfunction

  always @(posedge clk) begin
    m_v <= rst & act_pixel_valid;
    m_d <= relu(act_pixel_in);
  end
  assign act_result_valid = m_v | spur;
  assign act_result_out = m_d;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [NUM_REQ-1:0] rv, input logic rdy, input int base);
    req_valid = rv;
    out_ready = rdy;
    for (int g = 0; g < NUM_REQ; g++) req_data[g] = DATA_W'(base + g * 37);
  endtask

  task automatic step();
    sb_t e;
    #1;
    if (rst) begin
      for (int g = 0; g < NUM_REQ; g++)
        if (req_valid[g] && req_ready[g]) begin
          exp_q.push_back('{relu(req_data[g]), g, cyc});
          hs_cnt++;
        end
      if (out_valid && out_ready) begin
        chk("out_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("out_data", 64'(out_data), 64'(e.d));
          chk("out_id", 64'(out_id), 64'(e.id));
          if (chk_lat) chk("latency", 64'(cyc - e.c), 64'd3);
        end
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    spur = 1'b0;
    drive('0, 1'b0, 0);
    @(negedge clk);
    step();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_act_valid", 64'(act_pixel_valid), 64'd0);
    chk("rst_act_pixel", 64'(act_pixel_in), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_id", 64'(out_id), 64'd0);
    chk("rst_err", 64'(err_sync), 64'd0);
    rst = 1'b1;
    // single requester: -5 then 300 from requester 2
    drive(4'b0100, 1'b1, 0);
    req_data[2] = DATA_W'(-5);
    step();
    req_data[2] = DATA_W'(300);
    step();
    drive('0, 1'b1, 0);
    repeat (6) step();
    chk("t1_hs", 64'(hs_cnt), 64'd2);
    chk("t1_drain", 64'(exp_q.size()), 64'd0);
    chk("t1_err", 64'(err_sync), 64'd0);
    // all requesters valid: grants rotate from pointer 3, one per cycle
    h0 = hs_cnt;
    for (int s = 0; s < 12; s++) begin
      drive(4'b1111, 1'b1, s * 40 - 200);
      #1 chk("t2_grant", 64'(req_ready), 64'(4'b0001 << ((3 + s) % 4)));
      step();
    end
    chk("t2_hs", 64'(hs_cnt - h0), 64'd12);
    drive('0, 1'b1, 0);
    repeat (6) step();
    chk("t2_drain", 64'(exp_q.size()), 64'd0);
    // backpressure: credit stops issue after FIFO_DEPTH pixels
    chk_lat = 1'b0;
    h0 = hs_cnt;
    for (int s = 0; s < 8; s++) begin
      drive(4'b1111, 1'b0, 500 + s * 3);
      step();
    end
    chk("t3_hs", 64'(hs_cnt - h0), 64'd4);
    #1 chk("t3_blocked", 64'(req_ready), 64'd0);
    chk("t3_full_valid", 64'(out_valid), 64'd1);
    drive(4'b1111, 1'b1, 900);
    for (int k = 0; k < 10 && hs_cnt - h0 <= 4; k++) step();
    chk("t3_resume", 64'(hs_cnt - h0 > 4), 64'd1);
    drive('0, 1'b1, 0);
    repeat (10) step();
    chk("t3_drain", 64'(exp_q.size()), 64'd0);
    chk_lat = 1'b1;
    // sparse fairness: pointer parked at 2, then only 1 and 3 request
    drive(4'b0010, 1'b1, 77);
    step();
    for (int s = 0; s < 3; s++) begin
      drive(4'b1010, 1'b1, s * 5 - 3);
      #1 chk("t4_grant", 64'(req_ready), 64'(t4[s]));
      step();
    end
    drive('0, 1'b1, 0);
    repeat (6) step();
    chk("t4_drain", 64'(exp_q.size()), 64'd0);
    // reset mid-stream with pixels in flight
    chk_lat = 1'b0;
    for (int s = 0; s < 3; s++) begin
      drive(4'b1111, 1'b0, 1234 + s);
      step();
    end
    rst = 1'b0;
    drive('0, 1'b0, 0);
    step();
    exp_q.delete();
    rst = 1'b1;
    #1 chk("t5_out_valid", 64'(out_valid), 64'd0);
    chk("t5_act_valid", 64'(act_pixel_valid), 64'd0);
    step();
    chk_lat = 1'b1;
    drive(4'b1111, 1'b1, -40);
    #1 chk("t5_ptr", 64'(req_ready), 64'd1);
    step();
    drive('0, 1'b1, 0);
    repeat (6) step();
    chk("t5_drain", 64'(exp_q.size()), 64'd0);
    chk("t5_err", 64'(err_sync), 64'd0);
    // spurious result with nothing issued
    spur = 1'b1;
    step();
    spur = 1'b0;
    #1 chk("t6_err_set", 64'(err_sync), 64'd1);
    chk("t6_fifo", 64'(out_valid), 64'd0);
    repeat (3) step();
    chk("t6_err_sticky", 64'(err_sync), 64'd1);
    chk("t6_fifo_hold", 64'(out_valid), 64'd0);
    rst = 1'b0;
    step();
    rst = 1'b1;
    #1 chk("t6_err_clr", 64'(err_sync), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
